// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared types and constants for the 4x4 keypad scanner
// Holds the debounce FSM state encoding, matrix dimensions and the
// {valid, code} scan-result format with its NO_KEY value.
package keypad_scanner_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    typedef enum logic [1:0] {IDLE, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } result_t;
    localparam result_t NO_KEY = '{valid: 1'b0, code: 4'd0};
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines and debounced key outputs
// keypad_col   column lines, active-low (into the scanner)
// keypad_row   row drive, active-low one-hot-low (from the scanner)
// key_code     debounced key index row*4+col
// key_valid    one-cycle pulse per accepted press
// key_held     high while the debounced key is pressed
interface keypad_scanner_if;
    logic [3:0] keypad_col;
    logic [3:0] keypad_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input keypad_col, output keypad_row, key_code, key_valid, key_held);
    modport slave  (output keypad_col, input keypad_row, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// key_debounce: per-scan debounce FSM turning scan results into key events
// clk, rst      scan clock and asynchronous active-high reset
// scan_done_i   high on the edge that completes a full matrix scan
// result_i      {valid, code} of the first pressed key in that scan
// key_code_o    accepted key index, held after release
// key_valid_o   one-cycle pulse after each accepted press
// key_held_o    high from acceptance until the release is debounced
module key_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done_i,
    input  result_t    result_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);
    state_t     state_q;
    logic [3:0] cand_q;
    logic [3:0] cnt_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;
    logic       hit;
    logic       last;

    // hit: scan still shows the accepted key; last: this scan completes the run
    assign hit  = result_i.valid && result_i.code == key_code_q;
    assign last = cnt_q == 4'(DEBOUNCE_SCANS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done_i) begin
                case (state_q)
                    IDLE: begin
                        if (result_i.valid) begin
                            state_q <= PRESS_PEND;
                            cand_q  <= result_i.code;
                            cnt_q   <= 4'd1;
                        end
                    end
                    PRESS_PEND: begin
                        if (!result_i.valid) begin
                            state_q <= IDLE;
                        end else if (result_i.code != cand_q) begin
                            cand_q <= result_i.code;
                            cnt_q  <= 4'd1;
                        end else if (last) begin
                            state_q     <= PRESSED;
                            key_code_q  <= cand_q;
                            key_held_q  <= 1'b1;
                            key_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    PRESSED: begin
                        if (!hit) begin
                            state_q <= RELEASE_PEND;
                            cnt_q   <= 4'd1;
                        end
                    end
                    RELEASE_PEND: begin
                        if (hit) begin
                            state_q <= PRESSED;
                        end else if (last) begin
                            state_q    <= IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 key matrix and reports debounced key presses
// clk_10000Hz  scan clock
// reset        asynchronous active-high reset
// kp           keypad_scanner_if master: row drive out, column lines in,
//              key_code/key_valid/key_held out
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic clk_10000Hz,
    input  logic reset,
    keypad_scanner_if.master kp
);
    localparam int SW = $clog2(SETTLE_CYCLES);

    logic [3:0]                             sync1_q, sync2_q;
    logic [SW-1:0]                          slot_q, slot_d;
    logic [1:0]                             row_q, row_d;
    logic [3:0]                             row_drv_q, row_drv_d;
    logic [NUM_ROWS-2:0][NUM_COLS-1:0]      samp_q, samp_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]      rows;
    logic                                   sample_edge;
    logic                                   scan_done;
    result_t                                result;

    always_comb begin
        sample_edge = slot_q == SW'(SETTLE_CYCLES - 1);
        scan_done   = sample_edge && row_q == 2'd3;
        slot_d      = sample_edge ? '0 : slot_q + 1'b1;
        row_d       = sample_edge ? row_q + 2'd1 : row_q;
        row_drv_d   = ~(4'b0001 << row_d);
        for (int r = 0; r < NUM_ROWS - 1; r++)
            samp_d[r] = (sample_edge && row_q == 2'(r)) ? sync2_q : samp_q[r];
        // Last row is taken straight from the synchronizer on the completing edge.
        rows   = {sync2_q, samp_q};
        result = NO_KEY;
        // Descending sweep so the lowest pressed index is the one left standing.
        for (int r = NUM_ROWS - 1; r >= 0; r--)
            for (int c = NUM_COLS - 1; c >= 0; c--)
                if (!rows[r][c])
                    result = '{valid: 1'b1, code: 4'(r * NUM_COLS + c)};
    end

    always_ff @(posedge clk_10000Hz or posedge reset) begin
        if (reset) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            slot_q    <= '0;
            row_q     <= 2'd0;
            row_drv_q <= 4'b1110;
            samp_q    <= '1;
        end else begin
            sync1_q   <= kp.keypad_col;
            sync2_q   <= sync1_q;
            slot_q    <= slot_d;
            row_q     <= row_d;
            row_drv_q <= row_drv_d;
            samp_q    <= samp_d;
        end
    end

    assign kp.keypad_row = row_drv_q;

    key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk        (clk_10000Hz),
        .rst        (reset),
        .scan_done_i(scan_done),
        .result_i   (result),
        .key_code_o (kp.key_code),
        .key_valid_o(kp.key_valid),
        .key_held_o (kp.key_held)
    );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scoreboard bench for keypad_scanner
module tb_keypad_scanner;
    localparam int DEB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mask = 16'h0;
    int          total = 0;
    int          bad = 0;
    int          exp_q[$];
    bit          m_held;
    int          m_code, m_cand, m_run;

    keypad_scanner_if kp();

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(DEB)) dut (
        .clk_10000Hz(clk),
        .reset      (reset),
        .kp         (kp)
    );

    always #5 clk = ~clk;

    // Passive key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        kp.keypad_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.keypad_row[r] && mask[r*4+c]) kp.keypad_col[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 0; m_code = 0; m_cand = -1; m_run = 0;
        exp_q.delete();
    endtask

    // Reference: a key is accepted after DEB identical scans while nothing is held,
    // and released after DEB consecutive scans that do not show the held key.
    task automatic model_step(input logic [15:0] m);
        int res = lowest(m);
        if (!m_held) begin
            if (res >= 0 && res == m_cand) m_run++;
            else if (res >= 0) begin m_cand = res; m_run = 1; end
            else begin m_cand = -1; m_run = 0; end
            if (m_run == DEB) begin
                m_held = 1; m_code = m_cand; m_run = 0;
                exp_q.push_back(m_code);
            end
        end else begin
            m_run = (res != m_code) ? m_run + 1 : 0;
            if (m_run == DEB) begin m_held = 0; m_run = 0; m_cand = -1; end
        end
    endtask

    task automatic wait_scan();
        logic [3:0] prev = kp.keypad_row;
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (kp.keypad_row == 4'b1110 && prev == 4'b0111) ok = 1;
            prev = kp.keypad_row;
        end
        check("scan_boundary_seen", int'(ok), 1);
    endtask

    task automatic do_scan(input logic [15:0] m);
        mask = m;
        model_step(m);
        wait_scan();
        check("key_held", int'(kp.key_held), int'(m_held));
        check("key_code", int'(kp.key_code), m_code);
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) do_scan(m);
    endtask

    // Monitor: every pulse must match the next predicted press.
    always @(negedge clk) begin
        if (!reset && kp.key_valid) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
            else begin
                check("pulse_code", int'(kp.key_code), exp_q.pop_front());
                check("pulse_held", int'(kp.key_held), 1);
            end
        end
    end

    initial begin
        logic [15:0] m;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_row", int'(kp.keypad_row), 4'b1110);
        check("rst_code", int'(kp.key_code), 0);
        check("rst_valid", int'(kp.key_valid), 0);
        check("rst_held", int'(kp.key_held), 0);
        reset = 1'b0;
        model_step(16'h0);
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] e;
            @(negedge clk);
            e = ~(4'b0001 << ((k / 4) % 4));
            check("row_step", int'(kp.keypad_row), int'(e));
        end
        hold(16'h0, 60);
        hold(16'h0200, 40);
        hold(16'h0, 10);
        for (int i = 0; i < 12; i++) do_scan(i % 2 ? 16'h0 : 16'h0200);
        hold(16'h0200, 10);
        for (int i = 0; i < 6; i++) do_scan(i % 2 ? 16'h0200 : 16'h0);
        hold(16'h0, 10);
        hold(16'h0018, 10);
        hold(16'h0, 10);
        hold(16'h0200, 10);
        hold(16'h0040, 20);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("amid_held", int'(kp.key_held), 0);
        check("amid_valid", int'(kp.key_valid), 0);
        check("amid_code", int'(kp.key_code), 0);
        check("amid_row", int'(kp.keypad_row), 4'b1110);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(16'h0040, 10);
        for (int s = 0; s < 25; s++) begin
            case ($urandom_range(0, 3))
                0: m = 16'h0;
                3: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: m = 16'h1 << $urandom_range(0, 15);
            endcase
            hold(m, $urandom_range(1, 11));
        end
        hold(16'h0, 10);
        repeat (2) @(negedge clk);
        check("pending_pulses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the scanned dot-matrix display: drives a 4x4 key matrix one row at a time, reads the column lines, debounces, and reports one clean key press.
- Feeds the game controller with cell selections (key_code) and press events (key_valid).
- Runs on the same 10 kHz scan clock as the display.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each row is driven before its columns are sampled; minimum 3, to cover the 2-FF synchronizer.
- DEBOUNCE_SCANS, 8, consecutive identical full-scan results required to accept a press or a release; range 2..15.

Ports:
- clk_10000Hz  input  1  scan clock.
- reset  input  1  asynchronous, active-high reset.
- keypad_col  input  4  column lines, active-low (pulled up); bit c = column c.
- keypad_row  output  4  row drive, active-low, one-hot-low; bit r = row r.
- key_code  output  4  debounced key index = row*4 + col; holds its value after release.
- key_valid  output  1  single-cycle pulse per accepted press.
- key_held  output  1  high while the debounced key is considered pressed.

Behaviour:
- Reset values, applied asynchronously: keypad_row=4'b1110, key_code=0, key_valid=0, key_held=0, synchronizer FFs=4'b1111, slot and row counters=0, FSM in IDLE, debounce count=0.
- keypad_col passes through a 2-FF synchronizer before any use.
- Scan sequencing:
  - Slot counter s runs 0..SETTLE_CYCLES-1. Row counter r runs 0..3 and advances when s wraps; r wraps from 3 to 0.
  - keypad_row = ~(1<<r), registered. Order: 1110, 1101, 1011, 0111, repeating.
  - On the edge where s==SETTLE_CYCLES-1, the synchronized columns are captured as the row-r sample.
  - At that edge with r==3, a scan is complete. The scan result is the first pressed position in row-major order: lowest row first, then lowest column. Otherwise the result is NONE.
  - Multiple pressed keys report the lowest index. There is no ghost-key rejection.
  - Scan period = 4*SETTLE_CYCLES cycles, i.e. 16 cycles (1.6 ms) at default.
- Debounce FSM: evaluated only at scan-complete edges. cand = candidate code, cnt = debounce count.
  - IDLE: result k -> PRESS_PEND, cand=k, cnt=1. Result NONE -> stay.
  - PRESS_PEND:
    - Result == cand -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED, key_code<=cand, key_held<=1, key_valid<=1.
    - Result is a different key -> cand=new key, cnt=1.
    - Result NONE -> IDLE.
  - PRESSED: result == key_code -> stay. Anything else (NONE or a different key) -> RELEASE_PEND, cnt=1.
  - RELEASE_PEND:
    - Result != key_code -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held<=0.
    - Result == key_code -> back to PRESSED with no new pulse.
- key_valid is high for exactly the one cycle following the accepting scan-complete edge, then cleared.
- Rollover: a new key never produces a pulse until the previous key has fully released through RELEASE_PEND -> IDLE and is then debounced again from IDLE.
- Reset mid-operation clears everything immediately. A key still held after reset deassertion is treated as a fresh press and produces a new pulse after DEBOUNCE_SCANS scans.
- Worst-case press latency from the first stable scan: DEBOUNCE_SCANS scans + 1 cycle.

Decomposition:
- Shared package/include holds:
  - FSM state encoding: IDLE, PRESS_PEND, PRESSED, RELEASE_PEND.
  - NUM_ROWS=4, NUM_COLS=4.
  - NO_KEY flag encoding: 5-bit result {valid, code}.
- Sub-module key_debounce holds the FSM, counter, key_code/key_held/key_valid registers, and consumes {scan_done, result}.
- The top level holds the synchronizer, scan counters, row drive and priority encoder.

Test Plan:
1. Reset sequencing, defaults: assert reset -> keypad_row=1110, all outputs 0. Release with no key -> keypad_row steps 1110/1101/1011/0111 every 4 cycles, key_valid never rises in 1000 cycles.
2. Clean press: model key row2 col1 (keypad_col=1101 while keypad_row=1011) held steady -> exactly one key_valid pulse within 8*16+16+3 cycles, key_code=9, key_held=1. No further pulse over 500 more cycles.
3. Bouncy press: toggle key 9 every 20 cycles for 200 cycles, then hold steady -> exactly one key_valid pulse, key_code=9.
4. Release: release key 9 -> key_held falls after 8 consecutive empty scans (128-144 cycles). Release bouncing of 10 cycles -> no pulse. key_code stays 9.
5. Multi-key and rollover:
   - Hold keys 3 and 4 together -> key_code=3.
   - Switch from key 9 to key 6 with no gap -> key_held drops after 8 scans, then a new pulse with key_code=6 after 8 more scans.
6. Async reset mid-press: assert reset while PRESSED -> key_held, key_valid and key_code drop to 0 in the same cycle. Deassert with the key still held -> new pulse with the correct code after 8 scans.
